if_fetch: RTL and testbench



---
 rtl/if_fetch.sv | 173 +++++++++++++++++
 tb/tb_if_fetch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch
//  Brief    : Instruction fetch stage. It issues instruction memory requests,
//             keeps a one-entry stall buffer, uses a static branch predictor
//             (JAL and backward branches are taken), and drains an outstanding
//             request when a redirect arrives.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef IF_FETCH_DEFS
`define IF_FETCH_DEFS
`define HOLDPIP_BUS 2:0
`define HOLD_NONE   3'b000
`define HOLD_WAIT   3'b001
`define HOLD_FLUSH  3'b010
`define INST_NOP    32'h0000_0013
`endif

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [`HOLDPIP_BUS] hold_flag_i,
    input  logic                jump_enable_i,
    input  logic [31:0]         jump_addr_i,
    output logic                imem_req_o,
    output logic [31:0]         imem_addr_o,
    input  logic                imem_ack_i,
    input  logic [31:0]         imem_rdata_i,
    output logic [31:0]         inst_o,
    output logic [31:0]         inst_addr_o,
    output logic                predict_jump_enable_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HELD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [6:0]  c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] c_NOP        = `INST_NOP;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_target, w_target_nxt;
    logic [31:0] r_buf_inst, w_buf_inst_nxt;
    logic [31:0] r_buf_npc, w_buf_npc_nxt;
    logic        r_buf_pred, w_buf_pred_nxt;

    logic        w_stall;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_b;
    logic [31:0] w_pd_npc;
    logic        w_pd_pred;
    logic        w_req;
    logic [31:0] w_inst;
    logic        w_pred;

    assign w_stall = (hold_flag_i == `HOLD_WAIT) || (hold_flag_i == `HOLD_FLUSH);

    assign w_imm_j = {{12{imem_rdata_i[31]}}, imem_rdata_i[19:12], imem_rdata_i[20],
                      imem_rdata_i[30:21], 1'b0};
    assign w_imm_b = {{20{imem_rdata_i[31]}}, imem_rdata_i[7], imem_rdata_i[30:25],
                      imem_rdata_i[11:8], 1'b0};

    // Static predictor: JAL always taken, conditional branch taken when the offset is negative
    always_comb begin
        w_pd_pred = 1'b0;
        w_pd_npc  = r_pc + 32'd4;
        if (imem_rdata_i[6:0] == c_OPC_JAL) begin
            w_pd_pred = 1'b1;
            w_pd_npc  = r_pc + w_imm_j;
        end else if ((imem_rdata_i[6:0] == c_OPC_BRANCH) && imem_rdata_i[31]) begin
            w_pd_pred = 1'b1;
            w_pd_npc  = r_pc + w_imm_b;
        end
    end

    // Next-state and IF/ID output selection; a redirect outranks hold and prediction
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_target_nxt   = r_target;
        w_buf_inst_nxt = r_buf_inst;
        w_buf_npc_nxt  = r_buf_npc;
        w_buf_pred_nxt = r_buf_pred;
        w_req          = 1'b0;
        w_inst         = c_NOP;
        w_pred         = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (imem_ack_i) begin
                    if (jump_enable_i) begin
                        w_pc_nxt = jump_addr_i;
                    end else if (w_stall) begin
                        w_buf_inst_nxt = imem_rdata_i;
                        w_buf_npc_nxt  = w_pd_npc;
                        w_buf_pred_nxt = w_pd_pred;
                        w_state_nxt    = S_HELD;
                    end else begin
                        w_inst   = imem_rdata_i;
                        w_pred   = w_pd_pred;
                        w_pc_nxt = w_pd_npc;
                    end
                end else if (jump_enable_i) begin
                    // The request in flight must still complete; remember where to go afterwards
                    w_target_nxt = jump_addr_i;
                    w_state_nxt  = S_DRAIN;
                end
            end
            S_HELD: begin
                if (jump_enable_i || !w_stall) begin
                    w_pc_nxt       = jump_enable_i ? jump_addr_i : r_buf_npc;
                    w_buf_inst_nxt = c_NOP;
                    w_buf_npc_nxt  = 32'd0;
                    w_buf_pred_nxt = 1'b0;
                    w_state_nxt    = S_FETCH;
                end
                if (!jump_enable_i) begin
                    w_inst = r_buf_inst;
                    w_pred = r_buf_pred;
                end
            end
            S_DRAIN: begin
                w_req = 1'b1;
                if (jump_enable_i) begin
                    w_target_nxt = jump_addr_i;
                end
                if (imem_ack_i) begin
                    w_pc_nxt    = jump_enable_i ? jump_addr_i : r_target;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // State, PC, redirect target and stall buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_target   <= RESET_PC;
            r_buf_inst <= c_NOP;
            r_buf_npc  <= 32'd0;
            r_buf_pred <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_target   <= w_target_nxt;
            r_buf_inst <= w_buf_inst_nxt;
            r_buf_npc  <= w_buf_npc_nxt;
            r_buf_pred <= w_buf_pred_nxt;
        end
    end

    // While reset is high, nothing is requested or delivered, even before the registers settle
    assign imem_req_o            = w_req & ~rst;
    assign imem_addr_o           = r_pc;
    assign inst_o                = rst ? c_NOP : w_inst;
    assign inst_addr_o           = r_pc;
    assign predict_jump_enable_o = w_pred & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch
//  Brief    : Self-checking bench for if_fetch, with directed scenarios and
//             randomized traffic compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef IF_FETCH_DEFS
`define IF_FETCH_DEFS
`define HOLDPIP_BUS 2:0
`define HOLD_NONE   3'b000
`define HOLD_WAIT   3'b001
`define HOLD_FLUSH  3'b010
`define INST_NOP    32'h0000_0013
`endif

module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = `INST_NOP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  hold_flag_i = `HOLD_NONE;
    logic        jump_enable_i = 1'b0;
    logic [31:0] jump_addr_i = 32'd0;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = NOP;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        predict_jump_enable_o;

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .hold_flag_i           (hold_flag_i),
        .jump_enable_i         (jump_enable_i),
        .jump_addr_i           (jump_addr_i),
        .imem_req_o            (imem_req_o),
        .imem_addr_o           (imem_addr_o),
        .imem_ack_i            (imem_ack_i),
        .imem_rdata_i          (imem_rdata_i),
        .inst_o                (inst_o),
        .inst_addr_o           (inst_addr_o),
        .predict_jump_enable_o (predict_jump_enable_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit is_stall(input logic [2:0] h);
        return (h == `HOLD_WAIT) || (h == `HOLD_FLUSH);
    endfunction

    function automatic bit taken(input logic [31:0] i);
        return (i[6:0] == 7'h6F) || ((i[6:0] == 7'h63) && i[31]);
    endfunction

    function automatic logic [31:0] next_of(input logic [31:0] i, input logic [31:0] pc);
        logic [31:0] v;
        if (i[6:0] == 7'h6F) begin
            v = 32'(i[30:21]) * 2 + 32'(i[20]) * 2048 + 32'(i[19:12]) * 4096;
            if (i[31]) v = v - 32'h0010_0000;
            return pc + v;
        end else if ((i[6:0] == 7'h63) && i[31]) begin
            v = 32'(i[11:8]) * 2 + 32'(i[30:25]) * 32 + 32'(i[7]) * 2048;
            v = v - 32'd4096;
            return pc + v;
        end
        return pc + 32'd4;
    endfunction

    logic [31:0] m_pc   = RESET_PC;
    bit          m_held = 1'b0;
    bit          m_drain = 1'b0;
    logic [31:0] m_buf  = NOP;
    logic [31:0] m_tgt  = 32'd0;

    // Model state advance on each clock edge (reset takes effect immediately)
    always @(posedge clk or posedge rst) begin : mdl
        if (rst) begin
            m_pc    <= RESET_PC;
            m_held  <= 1'b0;
            m_drain <= 1'b0;
        end else if (m_held) begin
            if (jump_enable_i) begin
                m_pc <= jump_addr_i; m_held <= 1'b0;
            end else if (!is_stall(hold_flag_i)) begin
                m_pc <= next_of(m_buf, m_pc); m_held <= 1'b0;
            end
        end else if (m_drain) begin
            if (jump_enable_i) m_tgt <= jump_addr_i;
            if (imem_ack_i) begin
                m_pc    <= jump_enable_i ? jump_addr_i : m_tgt;
                m_drain <= 1'b0;
            end
        end else if (imem_ack_i) begin
            if (jump_enable_i) m_pc <= jump_addr_i;
            else if (is_stall(hold_flag_i)) begin
                m_held <= 1'b1; m_buf <= imem_rdata_i;
            end else m_pc <= next_of(imem_rdata_i, m_pc);
        end else if (jump_enable_i) begin
            m_drain <= 1'b1; m_tgt <= jump_addr_i;
        end
    end

    // Compare process: DUT outputs versus model on every falling edge
    always @(negedge clk) begin : cmp
        logic        e_req;
        logic [31:0] e_inst;
        logic        e_pred;
        bit          dlv;
        if (rst) begin
            e_req = 1'b0; e_inst = NOP; e_pred = 1'b0;
        end else if (m_held) begin
            e_req  = 1'b0;
            e_inst = jump_enable_i ? NOP : m_buf;
            e_pred = !jump_enable_i && taken(m_buf);
        end else begin
            e_req  = 1'b1;
            dlv    = !m_drain && imem_ack_i && !jump_enable_i && !is_stall(hold_flag_i);
            e_inst = dlv ? imem_rdata_i : NOP;
            e_pred = dlv && taken(imem_rdata_i);
        end
        chk("m_req", imem_req_o, e_req);
        if (e_req) chk("m_addr", imem_addr_o, m_pc);
        chk("m_inst", inst_o, e_inst);
        chk("m_inst_addr", inst_addr_o, m_pc);
        chk("m_pred", predict_jump_enable_o, e_pred);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit a, input logic [31:0] d, input logic [2:0] h,
                         input bit j, input logic [31:0] ja);
        @(posedge clk);
        #1;
        imem_ack_i = a; imem_rdata_i = d; hold_flag_i = h;
        jump_enable_i = j; jump_addr_i = ja;
        #2;
    endtask

    function automatic logic [31:0] rand_inst();
        case ($urandom % 4)
            0: return ($urandom & 32'hFFFF_F000) | 32'h0000_00EF;
            1: return ($urandom & 32'hFFFF_FF80) | 32'h0000_0063;
            2: return NOP;
            default: return $urandom;
        endcase
    endfunction

    initial begin : stim
        int rst_cnt;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_inst_addr", inst_addr_o, RESET_PC);
        chk("rst_pred", predict_jump_enable_o, 1'b0);
        @(posedge clk); #1 rst = 1'b0; #2;
        chk("first_req", imem_req_o, 1'b1);
        chk("first_addr", imem_addr_o, RESET_PC);

        // zero-wait stream of NOPs
        for (int k = 0; k < 4; k++) begin
            drive(1, NOP, `HOLD_NONE, 0, 0);
            chk("seq_addr", imem_addr_o, 32'(k * 4));
            chk("seq_pred", predict_jump_enable_o, 1'b0);
        end

        // stall with buffered instruction at 0x10
        drive(1, 32'h0010_0093, `HOLD_WAIT, 0, 0);
        chk("stall_first_inst", inst_o, NOP);
        chk("stall_first_addr", inst_addr_o, 32'h10);
        drive(0, NOP, `HOLD_WAIT, 0, 0);
        chk("held_req", imem_req_o, 1'b0);
        chk("held_inst", inst_o, 32'h0010_0093);
        drive(0, NOP, `HOLD_WAIT, 0, 0);
        drive(0, NOP, `HOLD_NONE, 0, 0);
        chk("release_inst", inst_o, 32'h0010_0093);
        drive(1, NOP, `HOLD_NONE, 0, 0);
        chk("resume_addr", imem_addr_o, 32'h14);
        drive(1, NOP, `HOLD_NONE, 0, 0);
        drive(1, NOP, `HOLD_NONE, 0, 0);

        // JAL +0x100 at 0x20
        drive(1, 32'h1000_00EF, `HOLD_NONE, 0, 0);
        chk("jal_addr", imem_addr_o, 32'h20);
        chk("jal_pred", predict_jump_enable_o, 1'b1);
        chk("jal_inst", inst_o, 32'h1000_00EF);
        // redirect with ack to 0x40
        drive(1, NOP, `HOLD_NONE, 1, 32'h40);
        chk("jal_target", imem_addr_o, 32'h120);
        chk("jump_ack_inst", inst_o, NOP);
        // backward branch -8 at 0x40
        drive(1, 32'hFE00_0CE3, `HOLD_NONE, 0, 0);
        chk("br_addr", imem_addr_o, 32'h40);
        chk("br_pred", predict_jump_enable_o, 1'b1);

        // redirect to 0x200 while ack withheld
        drive(0, NOP, `HOLD_NONE, 1, 32'h200);
        chk("br_target", imem_addr_o, 32'h38);
        drive(0, NOP, `HOLD_NONE, 0, 0);
        chk("drain_req", imem_req_o, 1'b1);
        chk("drain_addr", imem_addr_o, 32'h38);
        drive(1, 32'h1000_00EF, `HOLD_NONE, 0, 0);
        chk("drain_discard", inst_o, NOP);
        chk("drain_pred", predict_jump_enable_o, 1'b0);

        // redirect with ack to 0x80, then wrap test
        drive(1, NOP, `HOLD_NONE, 1, 32'h80);
        chk("drain_next", imem_addr_o, 32'h200);
        chk("jump_ack_inst2", inst_o, NOP);
        drive(1, NOP, `HOLD_NONE, 0, 0);
        chk("jump80", imem_addr_o, 32'h80);
        drive(1, NOP, `HOLD_NONE, 1, 32'hFFFF_FFFC);
        drive(1, NOP, `HOLD_NONE, 0, 0);
        chk("top_addr", inst_addr_o, 32'hFFFF_FFFC);
        drive(0, NOP, `HOLD_NONE, 1, 32'h300);
        chk("wrap_addr", imem_addr_o, 32'h0);

        // reset in the middle of a drain
        drive(0, NOP, `HOLD_NONE, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_req", imem_req_o, 1'b0);
        chk("mid_rst_inst", inst_o, NOP);
        @(posedge clk); #1 rst = 1'b0; #2;
        chk("post_rst_addr", imem_addr_o, RESET_PC);
        chk("post_rst_req", imem_req_o, 1'b1);

        // randomized traffic
        rst_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) rst = 1'b0;
            end
            jump_enable_i = ($urandom % 10) == 0;
            jump_addr_i   = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + 32'(($urandom % 4) * 4))
                                                   : ($urandom & 32'hFFFF_FFFC);
            imem_ack_i    = !rst && !m_held && (($urandom % 10) < 6);
            imem_rdata_i  = rand_inst();
            case ($urandom % 8)
                0: hold_flag_i = `HOLD_WAIT;
                1: hold_flag_i = `HOLD_FLUSH;
                2: hold_flag_i = 3'd3;
                default: hold_flag_i = `HOLD_NONE;
            endcase
            if (rst_cnt == 0 && ($urandom % 300) == 0) begin
                #1 rst = 1'b1;
                rst_cnt = 2;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
